// File: rtl/drive_ctrl_if.sv
// Speed command bus: one handshake carrying both channel targets.
interface drive_ctrl_if;
   logic              cmd_vld;
   logic              cmd_rdy;
   logic signed [8:0] lft_cmd;
   logic signed [8:0] rht_cmd;

   modport master (output cmd_vld, lft_cmd, rht_cmd, input cmd_rdy);
   modport slave  (input cmd_vld, lft_cmd, rht_cmd, output cmd_rdy);
endinterface

// File: rtl/drive_ctrl.sv
// Dual-channel motor drive sequencer: frame-locked duty slew limiting,
// reversals sequenced through zero with a dead frame, emergency stop.
//
// state    | meaning
// ---------+--------------------------------------------------------------
// ST_RUN   | duty tracks target magnitude in the current direction
// ST_DECEL | direction mismatch, ramping duty down toward zero
// ST_DEAD  | duty held at zero for one frame before the rev pin may flip
module drive_ctrl #(
   parameter int RAMP_STEP = 4
) (
   input  logic       clk,
   input  logic       rst_n,
   drive_ctrl_if.slave cmd,
   input  logic       estop,
   output logic [7:0] lft_duty,
   output logic [7:0] rht_duty,
   output logic       lft_rev,
   output logic       rht_rev,
   output logic       frm_tick,
   output logic       busy
);

   localparam logic [1:0] ST_RUN   = 2'd0;
   localparam logic [1:0] ST_DECEL = 2'd1;
   localparam logic [1:0] ST_DEAD  = 2'd2;

   localparam logic [7:0] STEP = 8'(RAMP_STEP);

   typedef struct packed {
      logic [1:0] st;
      logic [7:0] duty;
      logic       rev;
   } ch_t;

   logic [7:0] frm_cnt;
   logic       estop_lat;
   logic       lft_sgn, rht_sgn;
   logic [7:0] lft_mag, rht_mag;
   ch_t        lft_ch, rht_ch;
   ch_t        lft_nxt, rht_nxt;

   // Magnitude of a 9-bit signed command; -256 saturates to 255.
   function automatic logic [7:0] mag_of(input logic [8:0] c);
      logic [8:0] n;
      n = ~c + 9'd1;
      if (!c[8])
         return c[7:0];
      else if (n[8])
         return 8'hFF;
      else
         return n[7:0];
   endfunction

   // One slew step toward the target, landing exactly on it.
   function automatic logic [7:0] track(input logic [7:0] duty, input logic [7:0] tmag);
      logic [7:0] diff;
      if (duty < tmag) begin
         diff = tmag - duty;
         return duty + ((diff > STEP) ? STEP : diff);
      end else begin
         diff = duty - tmag;
         return duty - ((diff > STEP) ? STEP : diff);
      end
   endfunction

   // Per-channel sequencer evaluated at a frame boundary.
   function automatic ch_t ch_next(input ch_t cur, input logic tsgn, input logic [7:0] tmag);
      ch_t        nx;
      logic       mm;
      logic [7:0] dn;
      nx = cur;
      mm = (tsgn != cur.rev) && (tmag != 8'd0);
      dn = (cur.duty > STEP) ? cur.duty - STEP : 8'd0;
      case (cur.st)
         ST_RUN: begin
            if (!mm) begin
               nx.duty = track(cur.duty, tmag);
            end else if (cur.duty != 8'd0) begin
               // a ramp-down that already reaches zero goes straight to the
               // dead frame so a reversal costs ceil(d/step) decel frames
               nx.duty = dn;
               nx.st   = (dn == 8'd0) ? ST_DEAD : ST_DECEL;
            end else begin
               nx.st = ST_DEAD;
            end
         end
         ST_DECEL: begin
            if (!mm) begin
               nx.st   = ST_RUN;
               nx.duty = track(cur.duty, tmag);
            end else begin
               nx.duty = dn;
               if (dn == 8'd0) nx.st = ST_DEAD;
            end
         end
         ST_DEAD: begin
            nx.duty = 8'd0;
            nx.st   = ST_RUN;
            if (mm) nx.rev = ~cur.rev;
         end
         default: begin
            nx.st   = ST_RUN;
            nx.duty = 8'd0;
         end
      endcase
      return nx;
   endfunction

   assign frm_tick    = (frm_cnt == 8'hFF);
   assign cmd.cmd_rdy = !estop_lat;

   assign lft_nxt = ch_next(lft_ch, lft_sgn, lft_mag);
   assign rht_nxt = ch_next(rht_ch, rht_sgn, rht_mag);

   assign lft_duty = lft_ch.duty;
   assign rht_duty = rht_ch.duty;
   assign lft_rev  = lft_ch.rev;
   assign rht_rev  = rht_ch.rev;

   assign busy = (lft_ch.st != ST_RUN) || (rht_ch.st != ST_RUN) ||
                 (lft_ch.duty != lft_mag) || (rht_ch.duty != rht_mag);

   // Free-running frame counter, lock-stepped with the PWM generators.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n)
         frm_cnt <= 8'd0;
      else
         frm_cnt <= frm_cnt + 8'd1;
   end

   // Target capture and estop latch; estop wins over a same-cycle command.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         estop_lat <= 1'b0;
         lft_sgn   <= 1'b0;
         rht_sgn   <= 1'b0;
         lft_mag   <= 8'd0;
         rht_mag   <= 8'd0;
      end else if (estop) begin
         estop_lat <= 1'b1;
         lft_sgn   <= 1'b0;
         rht_sgn   <= 1'b0;
         lft_mag   <= 8'd0;
         rht_mag   <= 8'd0;
      end else begin
         estop_lat <= 1'b0;
         if (cmd.cmd_vld && cmd.cmd_rdy) begin
            lft_sgn <= cmd.lft_cmd[8];
            rht_sgn <= cmd.rht_cmd[8];
            lft_mag <= mag_of(cmd.lft_cmd);
            rht_mag <= mag_of(cmd.rht_cmd);
         end
      end
   end

   // Channel state advances only at frame boundaries; estop zeroes duty but keeps rev.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         lft_ch <= '{st: ST_RUN, duty: 8'd0, rev: 1'b0};
         rht_ch <= '{st: ST_RUN, duty: 8'd0, rev: 1'b0};
      end else if (estop) begin
         lft_ch.st   <= ST_RUN;
         lft_ch.duty <= 8'd0;
         rht_ch.st   <= ST_RUN;
         rht_ch.duty <= 8'd0;
      end else if (frm_tick) begin
         lft_ch <= lft_nxt;
         rht_ch <= rht_nxt;
      end
   end

endmodule

// File: tb/tb_drive_ctrl.sv
// Scoreboard bench for drive_ctrl: stimulus pushes expected outputs,
// a negedge monitor pops and compares them.
module tb_drive_ctrl;

   logic       clk   = 1'b0;
   logic       rst_n = 1'b0;
   logic       estop = 1'b0;
   logic [7:0] lft_duty, rht_duty;
   logic       lft_rev, rht_rev, frm_tick, busy;

   drive_ctrl_if bus();

   drive_ctrl #(.RAMP_STEP(4)) dut (
      .clk      (clk),
      .rst_n    (rst_n),
      .cmd      (bus),
      .estop    (estop),
      .lft_duty (lft_duty),
      .rht_duty (rht_duty),
      .lft_rev  (lft_rev),
      .rht_rev  (rht_rev),
      .frm_tick (frm_tick),
      .busy     (busy)
   );

   initial forever #5 clk = ~clk;

   typedef struct {
      string      name;
      logic [7:0] ld;
      logic       lr;
      logic [7:0] rd;
      logic       rr;
      logic       bz;
      logic       rdy;
   } exp_t;

   exp_t bq[$];
   exp_t cq[$];
   int   n_chk   = 0;
   int   n_fail  = 0;
   int   bnd_cnt = 0;
   int   idle    = 0;
   logic last_tick = 1'b0;

   function automatic exp_t mk(string nm, int ld, bit lr, int rd, bit rr, bit bz, bit rdy);
      exp_t e;
      e.name = nm; e.ld = 8'(ld); e.lr = lr; e.rd = 8'(rd); e.rr = rr; e.bz = bz; e.rdy = rdy;
      return e;
   endfunction

   task automatic cmp(string nm, string f, int act, int exp);
      n_chk++;
      if (act != exp) begin
         n_fail++;
         $display("FAIL %s.%s: got %0d expected %0d at %0t", nm, f, act, exp, $time);
      end
   endtask

   task automatic check(exp_t e);
      cmp(e.name, "lft_duty", int'(lft_duty), int'(e.ld));
      cmp(e.name, "lft_rev",  int'(lft_rev),  int'(e.lr));
      cmp(e.name, "rht_duty", int'(rht_duty), int'(e.rd));
      cmp(e.name, "rht_rev",  int'(rht_rev),  int'(e.rr));
      cmp(e.name, "busy",     int'(busy),     int'(e.bz));
      cmp(e.name, "cmd_rdy",  int'(bus.cmd_rdy), int'(e.rdy));
      cmp(e.name, "frm_tick", int'(frm_tick), 0);
   endtask

   // Monitor: cycle checks every negedge, boundary checks after each frame edge.
   always @(negedge clk) begin
      exp_t e;
      if (cq.size() > 0) begin
         e = cq.pop_front();
         check(e);
      end
      if (!rst_n) begin
         last_tick = 1'b0;
         idle      = 0;
      end else begin
         if (last_tick) begin
            bnd_cnt++;
            idle = 0;
            if (bq.size() > 0) begin
               e = bq.pop_front();
               check(e);
            end
         end else begin
            idle++;
            if (bq.size() > 0 && idle > 300) begin
               e = bq.pop_front();
               n_chk++;
               n_fail++;
               $display("FAIL watchdog %s: no frame boundary within 300 cycles", e.name);
               idle = 0;
            end
         end
         last_tick = frm_tick;
      end
   end

   task automatic wait_bnds(int n);
      int target = bnd_cnt + n;
      int budget = n * 300 + 10;
      while (bnd_cnt < target && budget > 0) begin
         @(negedge clk); #1;
         budget--;
      end
   endtask

   task automatic send(int l, int r);
      bus.cmd_vld = 1'b1;
      bus.lft_cmd = 9'(l);
      bus.rht_cmd = 9'(r);
      @(posedge clk); #1;
      bus.cmd_vld = 1'b0;
   endtask

   initial begin
      bus.cmd_vld = 1'b0;
      bus.lft_cmd = '0;
      bus.rht_cmd = '0;

      // reset values
      cq.push_back(mk("reset", 0, 0, 0, 0, 0, 1));
      repeat (3) @(negedge clk);
      #1 rst_n = 1'b1;

      // command captured on the boundary edge: old target used there
      for (int i = 0; i < 300; i++) begin
         @(negedge clk); #1;
         if (frm_tick) break;
      end
      bus.cmd_vld = 1'b1;
      bus.lft_cmd = 9'(40);
      bus.rht_cmd = 9'(0);
      bq.push_back(mk("race_b0", 0, 0, 0, 0, 1, 1));
      bq.push_back(mk("race_b1", 4, 0, 0, 0, 1, 1));
      bq.push_back(mk("race_b2", 8, 0, 0, 0, 1, 1));
      @(posedge clk); #1;
      bus.cmd_vld = 1'b0;
      wait_bnds(3);

      // reset mid-ramp, nothing resumes afterwards
      repeat (20) @(negedge clk);
      #1 rst_n = 1'b0;
      cq.push_back(mk("rst_mid", 0, 0, 0, 0, 0, 1));
      repeat (2) @(negedge clk);
      #1 rst_n = 1'b1;
      bq.push_back(mk("rst_after", 0, 0, 0, 0, 0, 1));
      wait_bnds(1);

      // ramp 0 -> 100
      send(100, 0);
      for (int k = 1; k <= 25; k++)
         bq.push_back(mk($sformatf("ramp_b%0d", k), 4 * k, 0, 0, 0, k < 25, 1));
      wait_bnds(25);

      // ramp down 100 -> 8
      send(8, 0);
      for (int k = 1; k <= 23; k++)
         bq.push_back(mk($sformatf("down_b%0d", k), 100 - 4 * k, 0, 0, 0, k < 23, 1));
      wait_bnds(23);

      // reversal +8 -> -8
      send(-8, 0);
      bq.push_back(mk("rev_b1", 4, 0, 0, 0, 1, 1));
      bq.push_back(mk("rev_b2", 0, 0, 0, 0, 1, 1));
      bq.push_back(mk("rev_b3", 0, 1, 0, 0, 1, 1));
      bq.push_back(mk("rev_b4", 4, 1, 0, 0, 1, 1));
      bq.push_back(mk("rev_b5", 8, 1, 0, 0, 0, 1));
      wait_bnds(5);

      // aborted reversal on the right channel
      send(-8, 20);
      for (int k = 1; k <= 5; k++)
         bq.push_back(mk($sformatf("abort_up_b%0d", k), 8, 1, 4 * k, 0, k < 5, 1));
      wait_bnds(5);
      send(-8, -20);
      bq.push_back(mk("abort_dec_b1", 8, 1, 16, 0, 1, 1));
      bq.push_back(mk("abort_dec_b2", 8, 1, 12, 0, 1, 1));
      wait_bnds(2);
      send(-8, 30);
      bq.push_back(mk("abort_run_b1", 8, 1, 16, 0, 1, 1));
      bq.push_back(mk("abort_run_b2", 8, 1, 20, 0, 1, 1));
      bq.push_back(mk("abort_run_b3", 8, 1, 24, 0, 1, 1));
      bq.push_back(mk("abort_run_b4", 8, 1, 28, 0, 1, 1));
      bq.push_back(mk("abort_run_b5", 8, 1, 30, 0, 0, 1));
      wait_bnds(5);

      // estop mid-ramp with a simultaneous command
      send(-8, 100);
      for (int k = 1; k <= 8; k++)
         bq.push_back(mk($sformatf("pre_estop_b%0d", k), 8, 1, 30 + 4 * k, 0, 1, 1));
      wait_bnds(8);
      estop = 1'b1;
      bus.cmd_vld = 1'b1;
      bus.lft_cmd = 9'(50);
      bus.rht_cmd = 9'(50);
      for (int k = 0; k < 10; k++)
         cq.push_back(mk($sformatf("estop_c%0d", k), 0, 1, 0, 0, 0, 0));
      repeat (10) @(negedge clk);
      #1;
      estop = 1'b0;
      bus.cmd_vld = 1'b0;
      cq.push_back(mk("estop_rel", 0, 1, 0, 0, 0, 1));
      bq.push_back(mk("estop_hold_b1", 0, 1, 0, 0, 0, 1));
      bq.push_back(mk("estop_hold_b2", 0, 1, 0, 0, 0, 1));
      wait_bnds(2);

      // saturation -256 on the right channel: dead frame, flip, ramp to 255
      send(0, -256);
      bq.push_back(mk("sat_dead", 0, 1, 0, 0, 1, 1));
      bq.push_back(mk("sat_flip", 0, 1, 0, 1, 1, 1));
      for (int k = 1; k <= 63; k++)
         bq.push_back(mk($sformatf("sat_b%0d", k), 0, 1, 4 * k, 1, 1, 1));
      bq.push_back(mk("sat_last", 0, 1, 255, 1, 0, 1));
      bq.push_back(mk("sat_hold", 0, 1, 255, 1, 0, 1));
      wait_bnds(67);

      for (int i = 0; i < 1000 && (bq.size() > 0 || cq.size() > 0); i++)
         @(negedge clk);
      repeat (2) @(negedge clk);
      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end

endmodule
